// File: rtl/env_mem_loader.sv
// Envelope memory loader: packs single I/Q samples into tslice-wide rows, commits
// them into a per-lane banked RAM, and serves a registered 1-cycle read port.
module env_mem_loader #(
    parameter int tslice = 4,
    parameter int aw = 10,
    parameter int dw = 16,
    localparam int tslicel = $clog2(tslice)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [aw+tslicel-1:0]      wr_addr,
    input  logic [2*dw-1:0]            wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic                       busy,
    output logic [15:0]                commit_count,
    input  logic [aw-1:0]              env_mem_raddr,
    output logic [2*dw*tslice-1:0]     env_data_out
);

    localparam int LW = (tslicel > 0) ? tslicel : 1;

    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_COMMIT} state_e;
    typedef logic [tslice-1:0] mask_t;

    state_e          state_q, state_d;
    mask_t           mask_q, mask_d;
    logic [aw-1:0]   row_q, row_d;
    logic [2*dw-1:0] lane_q [tslice];
    logic [2*dw-1:0] lane_d [tslice];
    logic [15:0]     count_q, count_d;

    logic [aw-1:0]   wr_row;
    logic [LW-1:0]   wr_lane;
    logic            commit;
    logic            accept;
    mask_t           base_mask;

    assign wr_row = wr_addr[aw+tslicel-1:tslicel];

    if (tslicel == 0) begin : g_one_lane
        assign wr_lane = '0;
    end else begin : g_lanes
        assign wr_lane = wr_addr[LW-1:0];
    end

    // A commit clears the mask at the same edge, so an accept on that edge starts
    // the next row from an empty mask instead of merging into the old one.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        row_d     = row_q;
        lane_d    = lane_q;
        count_d   = count_q;
        wr_ready  = 1'b1;
        commit    = 1'b0;
        accept    = 1'b0;
        base_mask = mask_q;

        case (state_q)
            S_EMPTY: wr_ready = !flush;
            S_FILL: begin
                if (flush || (wr_valid && (wr_row != row_q))) begin
                    wr_ready = 1'b0;
                    commit   = 1'b1;
                end
            end
            S_COMMIT: begin
                commit   = 1'b1;
                wr_ready = !flush;
            end
            default: state_d = S_EMPTY;
        endcase

        accept = wr_valid && wr_ready;

        if (commit) begin
            base_mask = '0;
            mask_d    = '0;
            count_d   = count_q + 16'd1;
            state_d   = S_EMPTY;
        end

        if (accept) begin
            row_d          = wr_row;
            lane_d[wr_lane] = wr_data;
            mask_d         = base_mask | (mask_t'(1) << wr_lane);
            state_d        = (mask_d == '1) ? S_COMMIT : S_FILL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
            mask_q  <= '0;
            row_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < tslice; k++) lane_q[k] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            count_q <= count_d;
            lane_q  <= lane_d;
        end
    end

    assign busy         = (mask_q != '0);
    assign commit_count = count_q;

    // One bank per lane; unmasked lanes of a partial row keep their RAM contents.
    for (genvar k = 0; k < tslice; k++) begin : g_bank
        logic [2*dw-1:0] mem [2**aw];
        logic [2*dw-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (commit && mask_q[k]) mem[row_q] <= lane_q[k];
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) rd_q <= '0;
            else       rd_q <= mem[env_mem_raddr];
        end

        assign env_data_out[2*dw*k +: 2*dw] = rd_q;
    end

endmodule

// File: tb/tb_env_mem_loader.sv
// Bench for env_mem_loader: directed scenarios with random sample data, checked
// against a row/lane memory model kept in plain arrays.
module tb_env_mem_loader;

  logic         clk = 1'b0;
  logic         rstn;
  logic [11:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         flush;
  logic         busy;
  logic [15:0]  commit_count;
  logic [9:0]   env_mem_raddr;
  logic [127:0] env_data_out;

  always #5 clk = ~clk;

  env_mem_loader dut (
    .clk(clk),
    .rstn(rstn),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .flush(flush),
    .busy(busy),
    .commit_count(commit_count),
    .env_mem_raddr(env_mem_raddr),
    .env_data_out(env_data_out)
  );

  int total = 0;
  int passed = 0;
  int failed = 0;

  // reference model: memory rows, pending row buffer, commit counter
  logic [31:0] mm [1024][4];
  logic [31:0] bd [4];
  logic [3:0]  bm;
  logic [9:0]  br;
  logic [15:0] mcount;

  function automatic void m_commit();
    if (bm != 4'h0) begin
      for (int k = 0; k < 4; k++) if (bm[k]) mm[br][k] = bd[k];
      bm = 4'h0;
      mcount = mcount + 16'd1;
    end
  endfunction

  function automatic void m_accept(input logic [9:0] row, input logic [1:0] lane,
                                   input logic [31:0] d);
    if (bm != 4'h0 && row != br) m_commit();
    if (bm == 4'h0) br = row;
    bd[lane] = d;
    bm[lane] = 1'b1;
    if (bm == 4'hf) m_commit();
  endfunction

  function automatic logic [127:0] pack(input logic [9:0] row);
    return {mm[row][3], mm[row][2], mm[row][1], mm[row][0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] row, input logic [1:0] lane, input logic [31:0] d);
    int n;
    int exp_stall;
    exp_stall = (bm != 4'h0 && row != br) ? 1 : 0;
    wr_addr = {row, lane};
    wr_data = d;
    wr_valid = 1'b1;
    flush = 1'b0;
    #1;
    n = 0;
    while (!wr_ready && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    @(posedge clk);
    #1;
    check("stall_cycles", 128'(n), 128'(exp_stall));
    m_accept(row, lane, d);
  endtask

  task automatic do_flush();
    wr_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_ready", 128'(wr_ready), 128'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    m_commit();
  endtask

  task automatic read_row(input string tag, input logic [9:0] row);
    wr_valid = 1'b0;
    env_mem_raddr = row;
    @(posedge clk);
    #1;
    check(tag, env_data_out, pack(row));
  endtask

  task automatic fill_row(input logic [9:0] row);
    for (int l = 0; l < 4; l++) send(row, 2'(l), $urandom());
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] old9;
    logic [9:0]   r;
    bm = 4'h0; br = '0; mcount = '0;
    for (int k = 0; k < 4; k++) bd[k] = '0;
    rstn = 1'b0;
    wr_addr = '0; wr_data = '0; wr_valid = 1'b0; flush = 1'b0; env_mem_raddr = '0;

    // reset state
    #23;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ready", 128'(wr_ready), 128'(1));
    check("rst_count", 128'(commit_count), 128'(0));
    check("rst_data", env_data_out, 128'(0));
    #4 rstn = 1'b1;
    @(posedge clk);
    #1;

    // sequential fill of row 5
    send(10'd5, 2'd0, 32'h00010002);
    send(10'd5, 2'd1, 32'h00030004);
    send(10'd5, 2'd2, 32'h00050006);
    send(10'd5, 2'd3, 32'h00070008);
    wr_valid = 1'b0;
    #1;
    check("fill_busy_pending", 128'(busy), 128'(1));
    check("fill_count_pending", 128'(commit_count), 128'(0));
    @(posedge clk);
    #1;
    check("fill_busy_done", 128'(busy), 128'(0));
    check("fill_count", 128'(commit_count), 128'(mcount));
    read_row("row5_model", 10'd5);
    check("row5_const", env_data_out, 128'h00070008_00050006_00030004_00010002);

    // partial row plus flush
    for (int l = 0; l < 4; l++) send(10'd7, 2'(l), 32'h11111111);
    idle();
    send(10'd7, 2'd2, 32'hAAAA5555);
    wr_valid = 1'b0;
    #1;
    check("partial_busy", 128'(busy), 128'(1));
    do_flush();
    check("flush_busy", 128'(busy), 128'(0));
    check("flush_count", 128'(commit_count), 128'(mcount));
    read_row("row7", 10'd7);
    check("row7_const", env_data_out, 128'h11111111_AAAA5555_11111111_11111111);

    // flush while empty is a no-op
    do_flush();
    check("empty_flush_count", 128'(commit_count), 128'(mcount));

    // row change stall
    fill_row(10'd3);
    fill_row(10'd4);
    send(10'd3, 2'd0, $urandom());
    send(10'd4, 2'd0, $urandom());
    do_flush();
    read_row("row3", 10'd3);
    read_row("row4", 10'd4);
    check("rowchg_count", 128'(commit_count), 128'(mcount));

    // back-to-back rows with read/write collision on row 9
    fill_row(10'd9);
    old9 = pack(10'd9);
    for (int l = 0; l < 4; l++) send(10'd9, 2'(l), $urandom());
    env_mem_raddr = 10'd9;
    send(10'd10, 2'd0, $urandom());
    check("collision_old", env_data_out, old9);
    send(10'd10, 2'd1, $urandom());
    check("collision_new", env_data_out, pack(10'd9));
    send(10'd10, 2'd2, $urandom());
    send(10'd10, 2'd3, $urandom());
    idle();
    read_row("row9", 10'd9);
    read_row("row10", 10'd10);
    check("b2b_count", 128'(commit_count), 128'(mcount));

    // randomized mix of rows, lanes and flushes
    for (int k = 20; k < 24; k++) fill_row(10'(k));
    for (int i = 0; i < 30; i++) begin
      r = 10'(20 + $urandom_range(0, 3));
      send(r, 2'($urandom_range(0, 3)), $urandom());
      if ($urandom_range(0, 4) == 0) do_flush();
    end
    do_flush();
    for (int k = 20; k < 24; k++) read_row("rand_row", 10'(k));
    check("rand_count", 128'(commit_count), 128'(mcount));

    // asynchronous reset in the middle of a row
    fill_row(10'd12);
    send(10'd12, 2'd0, $urandom());
    send(10'd12, 2'd1, $urandom());
    wr_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_count", 128'(commit_count), 128'(0));
    check("midrst_data", env_data_out, 128'(0));
    #1 rstn = 1'b1;
    bm = 4'h0;
    mcount = '0;
    @(posedge clk);
    #1;
    read_row("row12_kept", 10'd12);
    fill_row(10'd12);
    read_row("row12_new", 10'd12);
    check("postrst_count", 128'(commit_count), 128'(mcount));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/env_mem_loader.md
Name: env_mem_loader

Overview:
- Write-side counterpart of the envelope-memory read interface used by the pulse element.
- Accepts single I/Q envelope samples from the host/config bus, addressed per timeslice, and packs them into tslice-wide rows.
- Commits each row into a banked envelope RAM with per-lane write enables.
- Serves the element's read port (raddr in, 2*dw*tslice data out) with a fixed 1-cycle latency.

Parameters:
- tslice, 4: samples per clock (lanes per row).
- aw, 10: row address width; memory depth is 2**aw rows.
- dw, 16: width of each of I and Q.
- tslicel, $clog2(tslice): derived, never overridden; lane-select width (tslice==1 gives 0 lane bits).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- wr_addr  in  aw+tslicel  sample address; upper aw bits are the row, lower tslicel bits are the lane.
- wr_data  in  2*dw  sample; I in [dw-1:0], Q in [2*dw-1:dw].
- wr_valid  in  1  sample offered.
- wr_ready  out  1  sample accepted on a clk edge when wr_valid&wr_ready.
- flush  in  1  pulse; commit a partially filled row.
- busy  out  1  row buffer holds uncommitted lanes.
- commit_count  out  16  number of row commits since reset; wraps.
- env_mem_raddr  in  aw  read row address from the element.
- env_data_out  out  2*dw*tslice  row data; lane k is at [2*dw*(k+1)-1:2*dw*k].

Behaviour:
- Reset (rstn low, asynchronous):
  - Lane mask, row register, commit_count and env_data_out clear to 0.
  - wr_ready=1, busy=0.
  - RAM contents are not cleared.
  - A reset in the middle of a row discards the uncommitted lanes.
- Row buffer: tslice lane registers of 2*dw bits, a tslice-bit lane mask, and an aw-bit row register.
- States:
  - EMPTY: mask=0.
  - FILL: mask nonzero, not full.
  - COMMIT: a one-cycle RAM write.
  - busy = (mask!=0).
- Accept in EMPTY: latch the row, store the lane data, set its mask bit.
- Accept in FILL, same row:
  - Store the lane and set its mask bit.
  - A repeat write to the same lane overwrites; last value wins.
- Mask becomes full on an accept at edge N:
  - RAM write of all lanes occurs at edge N+1 and the mask clears.
  - wr_ready stays 1 during that cycle.
  - A sample accepted at edge N+1 starts the next row in the freshly cleared buffer, with no lost or merged lanes.
- Row change: wr_valid with a row different from the buffered row while busy:
  - wr_ready=0 that cycle.
  - Buffer commits at that edge; the sample is accepted the following cycle.
- flush:
  - While busy, commits only the masked lanes; unmasked lanes keep their old RAM contents (per-lane write enable).
  - flush has priority over wr_valid: wr_ready=0 during the flush cycle.
  - flush while EMPTY is a no-op; commit_count is unchanged.
  - flush coinciding with a pending full-row commit merges into that single commit; count +1.
- commit_count increments by exactly 1 per RAM row write and wraps 0xFFFF->0.
- Read port:
  - env_data_out is registered; data for env_mem_raddr sampled at edge N appears after edge N.
  - Read and write of the same row in the same cycle returns the old data; new data is visible on the next read.
  - The read port is never stalled by write activity.
- Width rule: the lane index is wr_addr[tslicel-1:0]. When tslice==1, lane is always 0 and every accept fills the row.

Test Plan:
- Sequential fill: write row 5 lanes 0..3 with data 0x00010002, 0x00030004, 0x00050006, 0x00070008 on consecutive cycles, wr_ready always 1 -> one commit 1 cycle after the last accept. Reading raddr=5 gives 0x00070008_00050006_00030004_00010002; commit_count=1.
- Partial plus flush: write row 7 lane 2 = 0xAAAA5555 over a row previously filled with 0x11111111 -> busy=1. After flush, reading row 7 gives lanes 0,1,3 = 0x11111111 and lane 2 = 0xAAAA5555; busy=0; commit_count +1.
- Row change stall: write row 3 lane 0, then offer row 4 lane 0 -> wr_ready=0 for exactly 1 cycle and row 3 commits. Row 4 lane 0 is accepted next cycle; both rows read back correctly.
- Back-to-back rows: 8 consecutive samples covering rows 9 and 10 with wr_valid held high -> wr_ready never drops; exactly 2 commits; both rows read back correct.
- Read latency and collision: raddr=9 presented in the same cycle as row 9's commit -> old data out; raddr=9 on the next cycle -> new data. Read latency is exactly 1 cycle.
- Reset mid-row: write 2 lanes of row 12, pulse rstn low asynchronously between clock edges -> busy=0 and commit_count=0 immediately; row 12 RAM unchanged; a subsequent fill of row 12 works normally.
